// File: rtl/modexp_trace_sequencer_if.sv
// Job request / response handshake bundle between a host and the modexp trace sequencer.
interface modexp_trace_sequencer_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RUN_CNT_W = 16
) ();
    logic                 req_valid;
    logic                 req_ready;
    logic [WIDTH-1:0]     req_m;
    logic [WIDTH-1:0]     req_d;
    logic [WIDTH-1:0]     req_n;
    logic [RUN_CNT_W-1:0] req_runs;
    logic                 res_valid;
    logic                 res_ready;
    logic [WIDTH-1:0]     res_data;
    logic                 res_err;

    modport master (
        output req_valid, req_m, req_d, req_n, req_runs, res_ready,
        input  req_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  req_valid, req_m, req_d, req_n, req_runs, res_ready,
        output req_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/modexp_trace_sequencer.sv
// Runs the modular_exp core N times per job with a scope trigger framing each run,
// and reports the first result plus a flag if any run disagreed or timed out.
module modexp_trace_sequencer #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned RUN_CNT_W      = 16,
    parameter int unsigned RST_CYCLES     = 2,
    parameter int unsigned GAP_CYCLES     = 20,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    modexp_trace_sequencer_if.slave bus,
    input  logic                 abort,
    output logic                 exp_reset,
    output logic [WIDTH-1:0]     exp_m,
    output logic [WIDTH-1:0]     exp_d,
    output logic [WIDTH-1:0]     exp_n,
    input  logic [WIDTH-1:0]     exp_result,
    input  logic                 exp_done,
    output logic                 trig,
    output logic                 busy,
    output logic [RUN_CNT_W-1:0] runs_done
);

    localparam int unsigned PH_MAX   = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
    localparam int unsigned PH_CNT_W = $clog2(PH_MAX + 1);
    localparam int unsigned TO_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CHECK,
        GAP,
        REPORT
    } state_t;

    state_t               state, state_n;
    logic [PH_CNT_W-1:0]  ph_cnt, ph_cnt_n;
    logic [TO_CNT_W-1:0]  to_cnt, to_cnt_n;
    logic [RUN_CNT_W-1:0] target, target_n;
    logic [RUN_CNT_W-1:0] runs_done_n;
    logic                 err, err_n;
    logic [WIDTH-1:0]     res_data_q, res_data_n;
    logic [WIDTH-1:0]     m_n, d_n, n_n;
    logic                 req_ready_q, res_valid_q, res_err_q;

    assign bus.req_ready = req_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;

    // Next-state and next-value logic for the job sequence.
    always_comb begin
        state_n     = state;
        ph_cnt_n    = ph_cnt;
        to_cnt_n    = to_cnt;
        target_n    = target;
        runs_done_n = runs_done;
        err_n       = err;
        res_data_n  = res_data_q;
        m_n         = exp_m;
        d_n         = exp_d;
        n_n         = exp_n;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    m_n         = bus.req_m;
                    d_n         = bus.req_d;
                    n_n         = bus.req_n;
                    target_n    = (bus.req_runs == '0) ? RUN_CNT_W'(1) : bus.req_runs;
                    runs_done_n = '0;
                    err_n       = 1'b0;
                    ph_cnt_n    = '0;
                    state_n     = LOAD;
                end
            end
            LOAD: begin
                if (ph_cnt == PH_CNT_W'(RST_CYCLES - 1)) begin
                    to_cnt_n = '0;
                    state_n  = RUN;
                end else begin
                    ph_cnt_n = ph_cnt + 1'b1;
                end
            end
            RUN: begin
                // The first RUN cycle ignores exp_done while the core leaves reset.
                if ((to_cnt != '0) && exp_done) begin
                    state_n = CHECK;
                end else if (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_n   = 1'b1;
                    state_n = REPORT;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            CHECK: begin
                runs_done_n = runs_done + 1'b1;
                if (runs_done == '0) begin
                    res_data_n = exp_result;
                end else if (exp_result != res_data_q) begin
                    err_n = 1'b1;
                end
                if (runs_done_n == target) begin
                    state_n = REPORT;
                end else begin
                    ph_cnt_n = '0;
                    state_n  = GAP;
                end
            end
            GAP: begin
                if (ph_cnt == PH_CNT_W'(GAP_CYCLES - 1)) begin
                    to_cnt_n = '0;
                    state_n  = RUN;
                end else begin
                    ph_cnt_n = ph_cnt + 1'b1;
                end
            end
            REPORT: begin
                if (bus.res_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (abort && (state != IDLE)) begin
            state_n = IDLE;
        end
    end

    // State, counters and outputs; outputs are registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ph_cnt      <= '0;
            to_cnt      <= '0;
            target      <= '0;
            runs_done   <= '0;
            err         <= 1'b0;
            res_data_q  <= '0;
            exp_m       <= '0;
            exp_d       <= '0;
            exp_n       <= '0;
            exp_reset   <= 1'b1;
            trig        <= 1'b0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            ph_cnt      <= ph_cnt_n;
            to_cnt      <= to_cnt_n;
            target      <= target_n;
            runs_done   <= runs_done_n;
            err         <= err_n;
            res_data_q  <= res_data_n;
            exp_m       <= m_n;
            exp_d       <= d_n;
            exp_n       <= n_n;
            exp_reset   <= !((state_n == RUN) || (state_n == CHECK));
            trig        <= (state_n == RUN);
            res_valid_q <= (state_n == REPORT);
            res_err_q   <= err_n;
            req_ready_q <= (state_n == IDLE);
            busy        <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_modexp_trace_sequencer.sv
// Self-checking bench for modexp_trace_sequencer with a behavioural modular_exp stub.
module tb_modexp_trace_sequencer;

    localparam int unsigned WIDTH          = 32;
    localparam int unsigned RUN_CNT_W      = 16;
    localparam int unsigned RST_CYCLES     = 2;
    localparam int unsigned GAP_CYCLES     = 20;
    localparam int unsigned TIMEOUT_CYCLES = 4096;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 abort;
    logic                 exp_reset;
    logic [WIDTH-1:0]     exp_m, exp_d, exp_n;
    logic [WIDTH-1:0]     exp_result = '0;
    logic                 exp_done = 1'b0;
    logic                 trig;
    logic                 busy;
    logic [RUN_CNT_W-1:0] runs_done;

    int npass = 0;
    int nfail = 0;
    int ntotal = 0;

    modexp_trace_sequencer_if #(.WIDTH(WIDTH), .RUN_CNT_W(RUN_CNT_W)) bus ();

    modexp_trace_sequencer #(
        .WIDTH(WIDTH), .RUN_CNT_W(RUN_CNT_W), .RST_CYCLES(RST_CYCLES),
        .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .abort(abort),
        .exp_reset(exp_reset), .exp_m(exp_m), .exp_d(exp_d), .exp_n(exp_n),
        .exp_result(exp_result), .exp_done(exp_done), .trig(trig),
        .busy(busy), .runs_done(runs_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        longint unsigned r, x;
        r = 64'd1 % 64'(m);
        x = 64'(b) % 64'(m);
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % 64'(m);
            x = (x * x) % 64'(m);
        end
        return 32'(r);
    endfunction

    // Core stub: 0 = real modexp, 1 = never finishes, 2 = scripted results per run.
    int          core_mode = 0;
    int          core_lat  = 5;
    logic [31:0] ovr [4];
    int          core_run  = 0;
    int          ccnt      = 0;

    always @(posedge clk) begin
        if (bus.req_valid && bus.req_ready) core_run <= 0;
        if (exp_reset) begin
            ccnt     <= 0;
            exp_done <= 1'b0;
        end else if (!exp_done) begin
            if ((ccnt + 1 >= core_lat) && (core_mode != 1)) begin
                exp_done   <= 1'b1;
                exp_result <= (core_mode == 2) ? ovr[core_run % 4] : modexp(exp_m, exp_d, exp_n);
                core_run   <= core_run + 1;
            end
            ccnt <= ccnt + 1;
        end
    end

    // Trigger monitor: pulse count, latency to first rise, low gap lengths, last high length.
    int   pulses = 0, gaps_seen = 0, gap_bad = 0, first_lat = -1;
    int   lat_cnt = 0, gap_len = 0, hi_len = 0, last_hi = 0;
    logic trig_d = 1'b0;

    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready) begin
            pulses = 0; gaps_seen = 0; gap_bad = 0; first_lat = -1;
            lat_cnt = 0; gap_len = 0; hi_len = 0; trig_d = 1'b0;
        end else begin
            lat_cnt++;
            if (trig && !trig_d) begin
                if (pulses == 0) first_lat = lat_cnt;
                else begin
                    gaps_seen++;
                    if (gap_len != GAP_CYCLES + 1) gap_bad++;
                end
                pulses++;
                hi_len  = 0;
                gap_len = 0;
            end
            if (trig) hi_len++;
            else begin
                if (trig_d) last_hi = hi_len;
                gap_len++;
            end
            trig_d = trig;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic start_job(input logic [31:0] m, input logic [31:0] d, input logic [31:0] n,
                             input logic [15:0] runs);
        int w;
        w = 0;
        while (!bus.req_ready && w < 100) begin tick(); w++; end
        check("req_ready_before_job", 64'(bus.req_ready), 64'd1);
        bus.req_m = m; bus.req_d = d; bus.req_n = n; bus.req_runs = runs;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        check("exp_m_latched", 64'(exp_m), 64'(m));
    endtask

    task automatic do_job(input logic [31:0] m, input logic [31:0] d, input logic [31:0] n,
                          input logic [15:0] runs, input int hold,
                          output logic [31:0] data, output logic err, output logic [15:0] rd);
        int w;
        start_job(m, d, n, runs);
        w = 0;
        while (!bus.res_valid && w < 40000) begin tick(); w++; end
        check("res_valid_arrives", 64'(bus.res_valid), 64'd1);
        data = bus.res_data;
        err  = bus.res_err;
        rd   = runs_done;
        check("exp_operands_stable", {exp_d, exp_n}, {d, n});
        for (int i = 0; i < hold; i++) begin
            tick();
            check("res_valid_hold", 64'(bus.res_valid), 64'd1);
            check("res_data_hold", 64'(bus.res_data), 64'(data));
            check("res_err_hold", 64'(bus.res_err), 64'(err));
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("res_valid_drop", 64'(bus.res_valid), 64'd0);
        check("req_ready_return", 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] data, m, d, n;
        logic        err;
        logic [15:0] rd, runs, exp_runs;
        int          w, hold;

        reset = 1'b0; abort = 1'b0;
        bus.req_valid = 1'b0; bus.req_m = '0; bus.req_d = '0; bus.req_n = '0;
        bus.req_runs = '0; bus.res_ready = 1'b0;
        ovr[0] = 32'd5; ovr[1] = 32'd6; ovr[2] = 32'd6; ovr[3] = 32'd6;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_exp_reset", 64'(exp_reset), 64'd1);
        check("rst_trig", 64'(trig), 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_runs_done", 64'(runs_done), 64'd0);

        // Single run
        core_mode = 0; core_lat = 5;
        do_job(32'd6, 32'd3, 32'd9, 16'd1, 0, data, err, rd);
        check("j1_data", 64'(data), 64'd0);
        check("j1_err", 64'(err), 64'd0);
        check("j1_runs_done", 64'(rd), 64'd1);
        check("j1_pulses", 64'(pulses), 64'd1);
        check("j1_first_trig_latency", 64'(first_lat), 64'(RST_CYCLES + 1));

        // Four back-to-back runs with fixed gaps
        core_lat = 7;
        do_job(32'd8, 32'd7, 32'd13, 16'd4, 0, data, err, rd);
        check("j2_data", 64'(data), 64'd5);
        check("j2_err", 64'(err), 64'd0);
        check("j2_runs_done", 64'(rd), 64'd4);
        check("j2_pulses", 64'(pulses), 64'd4);
        check("j2_gaps_seen", 64'(gaps_seen), 64'd3);
        check("j2_gap_len_bad", 64'(gap_bad), 64'd0);

        // runs=0 behaves as one run
        do_job(32'd8, 32'd7, 32'd13, 16'd0, 0, data, err, rd);
        check("j3_data", 64'(data), 64'd5);
        check("j3_runs_done", 64'(rd), 64'd1);
        check("j3_pulses", 64'(pulses), 64'd1);

        do_job(32'd63, 32'd3, 32'd17, 16'd2, 0, data, err, rd);
        check("j4_data", 64'(data), 64'd11);
        check("j4_err", 64'(err), 64'd0);

        // Response held off by res_ready low for 10 cycles
        do_job(32'd89, 32'd5, 32'd19, 16'd1, 10, data, err, rd);
        check("j5_data", 64'(data), 64'd14);
        check("j5_err", 64'(err), 64'd0);

        // Core never finishes
        core_mode = 1;
        do_job(32'd3, 32'd3, 32'd7, 16'd1, 0, data, err, rd);
        check("to_err", 64'(err), 64'd1);
        check("to_runs_done", 64'(rd), 64'd0);
        check("to_run_cycles", 64'(last_hi), 64'(TIMEOUT_CYCLES));

        // Results disagree between runs
        core_mode = 2; core_lat = 4;
        do_job(32'd3, 32'd3, 32'd7, 16'd2, 0, data, err, rd);
        check("mm_err", 64'(err), 64'd1);
        check("mm_data", 64'(data), 64'd5);
        check("mm_runs_done", 64'(rd), 64'd2);

        // Abort during the second of three runs
        core_mode = 0; core_lat = 30;
        start_job(32'd8, 32'd7, 32'd13, 16'd3);
        w = 0;
        while (!(trig && pulses == 2) && w < 2000) begin tick(); w++; end
        check("ab_reached_run2", 64'(pulses), 64'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_exp_reset", 64'(exp_reset), 64'd1);
        check("ab_trig", 64'(trig), 64'd0);
        check("ab_req_ready", 64'(bus.req_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ab_no_res_valid", 64'(bus.res_valid), 64'd0);
        end

        // Asynchronous reset in the middle of a gap
        core_lat = 5;
        start_job(32'd8, 32'd7, 32'd13, 16'd3);
        w = 0;
        while (!(pulses == 1 && !trig) && w < 2000) begin tick(); w++; end
        repeat (3) tick();
        check("rg_in_gap", {32'(busy), 32'(trig)}, {32'd1, 32'd0});
        reset = 1'b0;
        #1;
        check("rg_exp_reset", 64'(exp_reset), 64'd1);
        check("rg_trig", 64'(trig), 64'd0);
        check("rg_res_valid", 64'(bus.res_valid), 64'd0);
        check("rg_res_data", 64'(bus.res_data), 64'd0);
        check("rg_res_err", 64'(bus.res_err), 64'd0);
        check("rg_runs_done", 64'(runs_done), 64'd0);
        check("rg_operands", {exp_m, exp_d}, 64'd0);
        check("rg_req_ready_busy", {32'(bus.req_ready), 32'(busy)}, {32'd1, 32'd0});
        reset = 1'b1;
        tick();

        // Randomized jobs against the reference rules
        for (int j = 0; j < 12; j++) begin
            m = $urandom;
            d = $urandom_range(0, 65535);
            n = $urandom;
            if (n < 32'd2) n = 32'd2;
            runs = 16'($urandom_range(0, 4));
            hold = $urandom_range(0, 3);
            core_lat = $urandom_range(1, 40);
            exp_runs = (runs == 16'd0) ? 16'd1 : runs;
            do_job(m, d, n, runs, hold, data, err, rd);
            check("rnd_data", 64'(data), 64'(modexp(m, d, n)));
            check("rnd_err", 64'(err), 64'd0);
            check("rnd_runs_done", 64'(rd), 64'(exp_runs));
            check("rnd_pulses", 64'(pulses), 64'(exp_runs));
            check("rnd_gap_len_bad", 64'(gap_bad), 64'd0);
            check("rnd_first_trig_latency", 64'(first_lat), 64'(RST_CYCLES + 1));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
